// File: rtl/fp_mult_arbiter_if.sv
// Requester, multiplier and result signals of fp_mult_arbiter, bundled as one interface.
// The slave modport is the arbiter's view; master is the requester/multiplier side.
interface fp_mult_arbiter_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) ();
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ*2-1:0]     req_rnd;

   logic [WIDTH-1:0]         mult_a;
   logic [WIDTH-1:0]         mult_b;
   logic [1:0]               mult_rnd;
   logic [WIDTH-1:0]         mult_result;

   logic                     res_valid;
   logic [ID_W-1:0]          res_id;
   logic [WIDTH-1:0]         res_data;
   logic                     busy;

   modport master (
      output req_valid, req_a, req_b, req_rnd, mult_result,
      input  req_ready, mult_a, mult_b, mult_rnd, res_valid, res_id, res_data, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_rnd, mult_result,
      output req_ready, mult_a, mult_b, mult_rnd, res_valid, res_id, res_data, busy
   );
endinterface

// File: rtl/fp_mult_arbiter.sv
// Round-robin issue arbiter in front of a shared fixed-latency FP32 multiplier.
// A tag pipeline follows each issued pair so the product returns with its requester ID.
module fp_mult_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned MULT_LAT = 0
) (
   input logic              clk,
   input logic              rst,
   fp_mult_arbiter_if.slave bus
);
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;
   logic [NUM_REQ-1:0] ready;

   logic [WIDTH-1:0]   mult_a_q, mult_a_d;
   logic [WIDTH-1:0]   mult_b_q, mult_b_d;
   logic [1:0]         mult_rnd_q, mult_rnd_d;

   // Stage 0 lines up with the operands sitting on mult_*.
   logic [MULT_LAT:0]  tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]    tag_id_q [MULT_LAT+1];
   logic [ID_W-1:0]    tag_id_d [MULT_LAT+1];

   logic               res_valid_q, res_valid_d;
   logic [ID_W-1:0]    res_id_q, res_id_d;
   logic [WIDTH-1:0]   res_data_q, res_data_d;

   // First valid requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr_q) + k) % NUM_REQ;
         if (!grant_vld && bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(idx);
         end
      end
   end

   always_comb begin
      ready = '0;
      if (grant_vld) begin
         ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      mult_a_d   = mult_a_q;
      mult_b_d   = mult_b_q;
      mult_rnd_d = mult_rnd_q;
      if (grant_vld) begin
         ptr_d      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         mult_a_d   = bus.req_a[32'(grant_id) * WIDTH +: WIDTH];
         mult_b_d   = bus.req_b[32'(grant_id) * WIDTH +: WIDTH];
         mult_rnd_d = bus.req_rnd[32'(grant_id) * 2 +: 2];
      end
   end

   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = grant_vld;
      tag_id_d[0]  = grant_id;
      for (int unsigned k = 1; k <= MULT_LAT; k++) begin
         tag_vld_d[k] = tag_vld_q[k-1];
         tag_id_d[k]  = tag_id_q[k-1];
      end
   end

   always_comb begin
      res_valid_d = tag_vld_q[MULT_LAT];
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      if (tag_vld_q[MULT_LAT]) begin
         res_id_d   = tag_id_q[MULT_LAT];
         res_data_d = bus.mult_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q       <= '0;
         mult_a_q    <= '0;
         mult_b_q    <= '0;
         mult_rnd_q  <= '0;
         tag_vld_q   <= '0;
         tag_id_q    <= '{default: '0};
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mult_a_q    <= mult_a_d;
         mult_b_q    <= mult_b_d;
         mult_rnd_q  <= mult_rnd_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.mult_a    = mult_a_q;
   assign bus.mult_b    = mult_b_q;
   assign bus.mult_rnd  = mult_rnd_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = (|tag_vld_q) | res_valid_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: a zero-latency and a two-cycle-latency instance, each fed by a
// small truncating FP32 multiplier model; a round-robin model and result scoreboard watch u_dut0.
module tb_fp_mult_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_total = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_mult_arbiter_if #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) if0 ();
   fp_mult_arbiter_if #(.WIDTH(32), .NUM_REQ(4), .ID_W(2)) if2 ();

   fp_mult_arbiter #(.WIDTH(32), .NUM_REQ(4), .ID_W(2), .MULT_LAT(0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   fp_mult_arbiter #(.WIDTH(32), .NUM_REQ(4), .ID_W(2), .MULT_LAT(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2)
   );

   // Normal operands only; subnormal inputs flush to signed zero, mantissa truncated.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [9:0]  e;
      logic [47:0] p;
      logic [22:0] m;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {s, e[7:0], m};
   endfunction

   assign if0.mult_result = fmul(if0.mult_a, if0.mult_b);

   logic [31:0] p1, p2;
   always @(posedge clk) begin
      p1 <= fmul(if2.mult_a, if2.mult_b);
      p2 <= p1;
   end
   assign if2.mult_result = p2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] r);
      if0.req_a[i*32 +: 32] = a;
      if0.req_b[i*32 +: 32] = b;
      if0.req_rnd[i*2 +: 2] = r;
      if0.req_valid[i]      = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_mult_a"}, if0.mult_a, 32'd0);
      check_eq({tag, "_mult_b"}, if0.mult_b, 32'd0);
      check_eq({tag, "_mult_rnd"}, 32'(if0.mult_rnd), 32'd0);
      check_eq({tag, "_res_valid"}, 32'(if0.res_valid), 32'd0);
      check_eq({tag, "_res_id"}, 32'(if0.res_id), 32'd0);
      check_eq({tag, "_res_data"}, if0.res_data, 32'd0);
      check_eq({tag, "_busy"}, 32'(if0.busy), 32'd0);
   endtask

   task automatic lat2_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
      int          t0;
      int          lat;
      logic        seen;
      logic [31:0] got;
      seen = 1'b0;
      lat  = 0;
      got  = '0;
      if2.req_a[31:0]  = a;
      if2.req_b[31:0]  = b;
      if2.req_rnd[1:0] = 2'd0;
      if2.req_valid    = 4'b0001;
      @(negedge clk);
      t0 = cyc;
      check_eq({tag, "_ready"}, 32'(if2.req_ready), 32'd1);
      tick();
      if2.req_valid = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if2.res_valid && !seen) begin
            seen = 1'b1;
            lat  = cyc - t0;
            got  = if2.res_data;
         end
         tick();
      end
      check_eq({tag, "_seen"}, 32'(seen), 32'd1);
      check_eq({tag, "_lat"}, 32'(lat), 32'd4);
      check_eq({tag, "_data"}, got, exp);
   endtask

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];
   int   m_ptr = 0;

   // Round-robin reference model and in-order result scoreboard for u_dut0.
   initial begin
      exp_t       e;
      int         g;
      int         idx;
      logic       found;
      logic [3:0] exp_rdy;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_ptr = 0;
            sb.delete();
         end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
               e = sb.pop_front();
               check_eq("sb_valid", 32'(if0.res_valid), 32'd1);
               check_eq("sb_id", 32'(if0.res_id), 32'(e.id));
               check_eq("sb_data", if0.res_data, e.data);
            end else begin
               check_eq("sb_idle", 32'(if0.res_valid), 32'd0);
            end
            found = 1'b0;
            g     = 0;
            for (int k = 0; k < 4; k++) begin
               idx = (m_ptr + k) % 4;
               if (!found && if0.req_valid[idx]) begin
                  found = 1'b1;
                  g     = idx;
               end
            end
            exp_rdy = found ? 4'(1 << g) : 4'd0;
            check_eq("model_ready", 32'(if0.req_ready), 32'(exp_rdy));
            if (found) begin
               sb.push_back('{id: 2'(g), data: fmul(if0.req_a[g*32 +: 32], if0.req_b[g*32 +: 32]),
                              due: cyc + 2});
               m_ptr = (g + 1) % 4;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      if0.req_valid = '0;
      if0.req_a     = '0;
      if0.req_b     = '0;
      if0.req_rnd   = '0;
      if2.req_valid = '0;
      if2.req_a     = '0;
      if2.req_b     = '0;
      if2.req_rnd   = '0;
      tick();
      tick();
      @(negedge clk);
      check_reset_vals("rst0");
      check_eq("rst0_ready", 32'(if0.req_ready), 32'd0);
      tick();
      rst = 1'b0;

      // Single request from requester 1: 3.0 * 2.0.
      tick();
      set_req(1, 32'h4040_0000, 32'h4000_0000, 2'd0);
      @(negedge clk);
      check_eq("t1_ready", 32'(if0.req_ready), 32'h2);
      tick();
      if0.req_valid = '0;
      @(negedge clk);
      check_eq("t1_mult_a", if0.mult_a, 32'h4040_0000);
      check_eq("t1_mult_b", if0.mult_b, 32'h4000_0000);
      check_eq("t1_busy", 32'(if0.busy), 32'd1);
      tick();
      @(negedge clk);
      check_eq("t1_res_valid", 32'(if0.res_valid), 32'd1);
      check_eq("t1_res_id", 32'(if0.res_id), 32'd1);
      check_eq("t1_res_data", if0.res_data, 32'h40C0_0000);
      tick();
      // Pointer now at 2: with 0 and 2 both valid, 2 wins.
      set_req(0, 32'h3FC0_0000, 32'h4000_0000, 2'd1);
      set_req(2, 32'hC000_0000, 32'h3F00_0000, 2'd2);
      @(negedge clk);
      check_eq("t1_ptr2", 32'(if0.req_ready), 32'h4);
      tick();
      if0.req_valid[2] = 1'b0;
      @(negedge clk);
      check_eq("t1_next0", 32'(if0.req_ready), 32'h1);
      check_eq("t1_rnd", 32'(if0.mult_rnd), 32'd2);
      check_eq("t1_mult_a2", if0.mult_a, 32'hC000_0000);
      tick();
      if0.req_valid = '0;
      repeat (4) tick();

      // All four valid straight out of reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 32'h3FC0_0000, 32'h4000_0000, 2'd0);
      set_req(1, 32'h4040_0000, 32'h4000_0000, 2'd1);
      set_req(2, 32'hC000_0000, 32'h3F00_0000, 2'd2);
      set_req(3, 32'h3FA0_0000, 32'h3FA0_0000, 2'd3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("t2_grant", 32'(if0.req_ready), 32'd1 << i);
         tick();
         if0.req_valid[i] = 1'b0;
      end
      repeat (5) tick();

      // Fairness: 0 and 2 held valid continuously.
      set_req(0, 32'h4080_0000, 32'h3F40_0000, 2'd0);
      set_req(2, 32'hBF80_0000, 32'h4100_0000, 2'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("t3_alt", 32'(if0.req_ready), (i % 2 == 0) ? 32'h1 : 32'h4);
         tick();
      end
      if0.req_valid = '0;
      repeat (4) tick();

      // Requester 3 back-to-back for six cycles.
      for (int i = 0; i < 6; i++) begin
         set_req(3, 32'h3F80_0000 | (32'(i) << 19), 32'h4000_0000, 2'(i));
         @(negedge clk);
         check_eq("t4_ready", 32'(if0.req_ready), 32'h8);
         tick();
      end
      if0.req_valid = '0;
      @(negedge clk);
      check_eq("t4_busy1", 32'(if0.busy), 32'd1);
      tick();
      @(negedge clk);
      check_eq("t4_busy2", 32'(if0.busy), 32'd1);
      tick();
      @(negedge clk);
      check_eq("t4_busy3", 32'(if0.busy), 32'd0);
      tick();

      // Reset while two products are in flight.
      set_req(0, 32'h4040_0000, 32'h4040_0000, 2'd0);
      set_req(1, 32'h4000_0000, 32'h4000_0000, 2'd0);
      @(negedge clk);
      check_eq("t5_g0", 32'(if0.req_ready), 32'h1);
      tick();
      if0.req_valid[0] = 1'b0;
      @(negedge clk);
      check_eq("t5_g1", 32'(if0.req_ready), 32'h2);
      #2;
      rst = 1'b1;
      if0.req_valid = '0;
      tick();
      @(negedge clk);
      check_reset_vals("t5_rst");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t5_no_res", 32'(if0.res_valid), 32'd0);
         tick();
      end
      set_req(2, 32'h4100_0000, 32'h3E80_0000, 2'd1);
      set_req(3, 32'h4040_0000, 32'h4040_0000, 2'd0);
      @(negedge clk);
      check_eq("t5_first", 32'(if0.req_ready), 32'h4);
      tick();
      if0.req_valid[2] = 1'b0;
      @(negedge clk);
      check_eq("t5_second", 32'(if0.req_ready), 32'h8);
      tick();
      if0.req_valid = '0;
      @(negedge clk);
      check_eq("t5_res_valid", 32'(if0.res_valid), 32'd1);
      check_eq("t5_res_id", 32'(if0.res_id), 32'd2);
      check_eq("t5_res_data", if0.res_data, 32'h4000_0000);
      tick();
      repeat (3) tick();

      // Two-cycle multiplier build.
      lat2_run("l2_mul", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000);
      lat2_run("l2_zero", 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000);

      repeat (3) tick();
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
